// File: rtl/aux_reg_bridge_pkg.sv
// Shared opcode values, FSM state encoding and a state helper for aux_reg_bridge.
package aux_reg_bridge_pkg;

  localparam logic [7:0] AUX_CMD_WRITE = 8'h01;
  localparam logic [7:0] AUX_CMD_READ  = 8'h02;

  // Byte returned to the host when a read access times out.
  localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CMD     = 4'd1,
    ST_ADDR    = 4'd2,
    ST_LEN     = 4'd3,
    ST_WR_WAIT = 4'd4,
    ST_WR_BUS  = 4'd5,
    ST_RD_BUS  = 4'd6,
    ST_RD_SEND = 4'd7,
    ST_DONE    = 4'd8
  } aux_state_t;

  // States in which a host byte may be taken from the aux stream.
  function automatic logic takes_host_byte(input aux_state_t s);
    return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_LEN) || (s == ST_WR_WAIT);
  endfunction

endpackage

// File: rtl/aux_reg_bridge.sv
// Bridges the bootloader aux opcode stream onto a byte-wide register bus.
// Packet: CMD, ADDR, LEN, then LEN write bytes (WRITE) or LEN returned bytes (READ).
module aux_reg_bridge
  import aux_reg_bridge_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int AUTO_INC    = 1,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              aux_active,
  output logic              aux_complete,
  input  logic [7:0]        aux_data_out,
  input  logic              aux_data_out_valid,
  output logic              aux_data_out_ready,
  output logic [7:0]        aux_data_in,
  output logic              aux_data_in_valid,
  input  logic              aux_data_in_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
);

  localparam logic [15:0]       TMO       = 16'(BUS_TIMEOUT);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(AUTO_INC != 0);

  aux_state_t        state, state_d;
  logic              is_rd, is_rd_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [8:0]        cnt, cnt_d;
  logic [7:0]        wdata, wdata_d;
  logic [7:0]        rbuf, rbuf_d;
  logic              we, we_d, re, re_d;
  logic              pend, pend_d;
  logic [15:0]       tmr, tmr_d;
  logic              err, err_d;
  logic              ready, ready_d;

  logic accept, bus_done, send;

  assign accept   = aux_data_out_valid && ready;
  // A pending access finishes on ack (including the strobe cycle) or on timeout.
  assign bus_done = pend && (bus_ack || (tmr == TMO));
  // The return strobe is suppressed the moment the session is abandoned.
  assign send     = (state == ST_RD_SEND) && aux_active && aux_data_in_ready;

  assign aux_complete       = (state == ST_DONE);
  assign aux_data_out_ready = ready;
  assign aux_data_in        = rbuf;
  assign aux_data_in_valid  = send;
  assign bus_addr           = addr;
  assign bus_wdata          = wdata;
  assign bus_we             = we;
  assign bus_re             = re;
  assign bus_err            = err;

  // Next-state, strobe and datapath-register computation.
  always_comb begin
    state_d = state;
    is_rd_d = is_rd;
    addr_d  = addr;
    cnt_d   = cnt;
    wdata_d = wdata;
    rbuf_d  = rbuf;
    we_d    = 1'b0;
    re_d    = 1'b0;
    pend_d  = pend;
    tmr_d   = tmr;
    err_d   = err;

    unique case (state)
      ST_IDLE: begin
        if (aux_active) begin
          state_d = ST_CMD;
          err_d   = 1'b0;
          pend_d  = 1'b0;
        end
      end
      ST_CMD: begin
        if (accept) begin
          if (aux_data_out == AUX_CMD_WRITE) begin
            is_rd_d = 1'b0;
            state_d = ST_ADDR;
          end else if (aux_data_out == AUX_CMD_READ) begin
            is_rd_d = 1'b1;
            state_d = ST_ADDR;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ADDR: begin
        if (accept) begin
          addr_d  = ADDR_W'(aux_data_out);
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (accept) begin
          // A length byte of zero encodes a full 256-byte burst.
          cnt_d   = (aux_data_out == 8'd0) ? 9'd256 : {1'b0, aux_data_out};
          state_d = is_rd ? ST_RD_BUS : ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (accept) begin
          wdata_d = aux_data_out;
          state_d = ST_WR_BUS;
        end
      end
      ST_WR_BUS: begin
        if (!pend) begin
          we_d   = 1'b1;
          pend_d = 1'b1;
          tmr_d  = 16'd0;
        end else if (bus_done) begin
          pend_d  = 1'b0;
          err_d   = err | ~bus_ack;
          cnt_d   = cnt - 9'd1;
          addr_d  = addr + ADDR_STEP;
          state_d = (cnt == 9'd1) ? ST_DONE : ST_WR_WAIT;
        end else begin
          tmr_d = tmr + 16'd1;
        end
      end
      ST_RD_BUS: begin
        if (!pend) begin
          re_d   = 1'b1;
          pend_d = 1'b1;
          tmr_d  = 16'd0;
        end else if (bus_done) begin
          pend_d  = 1'b0;
          err_d   = err | ~bus_ack;
          rbuf_d  = bus_ack ? bus_rdata : TIMEOUT_RDATA;
          state_d = ST_RD_SEND;
        end else begin
          tmr_d = tmr + 16'd1;
        end
      end
      ST_RD_SEND: begin
        if (send) begin
          cnt_d   = cnt - 9'd1;
          addr_d  = addr + ADDR_STEP;
          state_d = (cnt == 9'd1) ? ST_DONE : ST_RD_BUS;
        end
      end
      ST_DONE: begin
        if (!aux_active) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Host abandoned the session: stop issuing strobes and drop any pending work.
    if (!aux_active && (state != ST_IDLE) && (state != ST_DONE)) begin
      state_d = ST_IDLE;
      we_d    = 1'b0;
      re_d    = 1'b0;
      pend_d  = 1'b0;
    end

    // Ready is registered and falls for one cycle after every accepted byte.
    ready_d = takes_host_byte(state_d) && !accept;
  end

  // State and register update; every register clears on reset so all outputs read 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      is_rd <= 1'b0;
      addr  <= '0;
      cnt   <= 9'd0;
      wdata <= 8'd0;
      rbuf  <= 8'd0;
      we    <= 1'b0;
      re    <= 1'b0;
      pend  <= 1'b0;
      tmr   <= 16'd0;
      err   <= 1'b0;
      ready <= 1'b0;
    end else begin
      state <= state_d;
      is_rd <= is_rd_d;
      addr  <= addr_d;
      cnt   <= cnt_d;
      wdata <= wdata_d;
      rbuf  <= rbuf_d;
      we    <= we_d;
      re    <= re_d;
      pend  <= pend_d;
      tmr   <= tmr_d;
      err   <= err_d;
      ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_aux_reg_bridge.sv
// Directed self-checking bench for aux_reg_bridge (BUS_TIMEOUT = 8).
module tb_aux_reg_bridge;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       aux_active = 1'b0;
  logic       aux_complete;
  logic [7:0] aux_data_out = 8'd0;
  logic       aux_data_out_valid = 1'b0;
  logic       aux_data_out_ready;
  logic [7:0] aux_data_in;
  logic       aux_data_in_valid;
  logic       aux_data_in_ready = 1'b1;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic       bus_ack;
  logic       bus_err;
  logic       ack_en = 1'b1;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int collide = 0;
  logic cmpl_seen = 1'b0;

  logic [7:0] we_addr_q[$];
  logic [7:0] we_data_q[$];
  logic [7:0] re_addr_q[$];
  logic [7:0] rd_q[$];
  int         we_cyc_q[$];
  int         re_cyc_q[$];
  int         rdv_cyc_q[$];

  aux_reg_bridge #(.ADDR_W(8), .AUTO_INC(1), .BUS_TIMEOUT(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .aux_active         (aux_active),
    .aux_complete       (aux_complete),
    .aux_data_out       (aux_data_out),
    .aux_data_out_valid (aux_data_out_valid),
    .aux_data_out_ready (aux_data_out_ready),
    .aux_data_in        (aux_data_in),
    .aux_data_in_valid  (aux_data_in_valid),
    .aux_data_in_ready  (aux_data_in_ready),
    .bus_addr           (bus_addr),
    .bus_wdata          (bus_wdata),
    .bus_we             (bus_we),
    .bus_re             (bus_re),
    .bus_rdata          (bus_rdata),
    .bus_ack            (bus_ack),
    .bus_err            (bus_err)
  );

  always #5 clk = ~clk;

  // Register model: acks in the strobe cycle, read data is address ^ 0x5A.
  assign bus_ack   = ack_en && (bus_we || bus_re);
  assign bus_rdata = bus_addr ^ 8'h5A;

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Log bus strobes and returned bytes, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus_we) begin
      we_addr_q.push_back(bus_addr);
      we_data_q.push_back(bus_wdata);
      we_cyc_q.push_back(cyc);
    end
    if (bus_re) begin
      re_addr_q.push_back(bus_addr);
      re_cyc_q.push_back(cyc);
    end
    if (bus_we && bus_re) collide <= collide + 1;
    if (aux_data_in_valid) begin
      rd_q.push_back(aux_data_in);
      rdv_cyc_q.push_back(cyc);
    end
    if (aux_complete) cmpl_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    we_addr_q.delete();
    we_data_q.delete();
    re_addr_q.delete();
    rd_q.delete();
    we_cyc_q.delete();
    re_cyc_q.delete();
    rdv_cyc_q.delete();
    cmpl_seen = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!aux_data_out_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!aux_data_out_ready) begin
      check("ready_wait", 32'(aux_data_out_ready), 32'd1);
    end else begin
      acc_cyc = cyc;
      aux_data_out = b;
      aux_data_out_valid = 1'b1;
      @(negedge clk);
      aux_data_out_valid = 1'b0;
      check("ready_drop", 32'(aux_data_out_ready), 32'd0);
    end
  endtask

  task automatic wait_cmpl(input string tag);
    int n = 0;
    while (!aux_complete && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(aux_complete), 32'd1);
  endtask

  task automatic wait_rd(input int want, input string tag);
    int k = 0;
    while (rd_q.size() < want && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(rd_q.size()), 32'(want));
  endtask

  task automatic end_session();
    aux_active = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int acc_aa;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outs", 32'({aux_complete, aux_data_out_ready, aux_data_in_valid, bus_we, bus_re,
                           bus_err, bus_addr, bus_wdata, aux_data_in}), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // WRITE 01 10 03 AA BB CC
    clear_logs();
    aux_active = 1'b1;
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'h03);
    send_byte(8'hAA);
    acc_aa = acc_cyc;
    send_byte(8'hBB);
    send_byte(8'hCC);
    wait_cmpl("wr_cmpl");
    check("wr_cnt", 32'(we_addr_q.size()), 32'd3);
    check("wr_a0", 32'(we_addr_q[0]), 32'h10);
    check("wr_a1", 32'(we_addr_q[1]), 32'h11);
    check("wr_a2", 32'(we_addr_q[2]), 32'h12);
    check("wr_d0", 32'(we_data_q[0]), 32'hAA);
    check("wr_d1", 32'(we_data_q[1]), 32'hBB);
    check("wr_d2", 32'(we_data_q[2]), 32'hCC);
    check("wr_lat", 32'(we_cyc_q[0] - acc_aa), 32'd2);
    check("wr_no_re", 32'(re_cyc_q.size()), 32'd0);
    check("wr_err", 32'(bus_err), 32'd0);
    end_session();
    check("wr_cmpl_off", 32'(aux_complete), 32'd0);

    // READ 02 FE 03 with address wrap
    clear_logs();
    aux_active = 1'b1;
    send_byte(8'h02);
    send_byte(8'hFE);
    send_byte(8'h03);
    wait_rd(3, "rd_n");
    check("rd_b0", 32'(rd_q[0]), 32'hA4);
    check("rd_b1", 32'(rd_q[1]), 32'hA5);
    check("rd_b2", 32'(rd_q[2]), 32'h5A);
    check("rd_a2", 32'(re_addr_q[2]), 32'h00);
    check("rd_lat", 32'(rdv_cyc_q[0] - re_cyc_q[0]), 32'd1);
    wait_cmpl("rd_cmpl");
    check("rd_no_we", 32'(we_cyc_q.size()), 32'd0);
    end_session();

    // READ with upstream stalled for 20 cycles
    clear_logs();
    aux_data_in_ready = 1'b0;
    aux_active = 1'b1;
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h01);
    repeat (20) @(negedge clk);
    check("stall_novld", 32'(rd_q.size()), 32'd0);
    check("stall_one_re", 32'(re_cyc_q.size()), 32'd1);
    @(posedge clk);
    #1 aux_data_in_ready = 1'b1;
    wait_rd(1, "stall_n");
    check("stall_b0", 32'(rd_q[0]), 32'h7A);
    check("stall_re_total", 32'(re_cyc_q.size()), 32'd1);
    wait_cmpl("stall_cmpl");
    end_session();

    // Bus timeout on a read
    clear_logs();
    ack_en = 1'b0;
    aux_active = 1'b1;
    send_byte(8'h02);
    send_byte(8'h30);
    send_byte(8'h01);
    wait_rd(1, "tmo_n");
    check("tmo_b0", 32'(rd_q[0]), 32'hFF);
    check("tmo_lat", 32'(rdv_cyc_q[0] - re_cyc_q[0]), 32'd9);
    check("tmo_err", 32'(bus_err), 32'd1);
    wait_cmpl("tmo_cmpl");
    end_session();
    check("tmo_err_sticky", 32'(bus_err), 32'd1);
    ack_en = 1'b1;

    // Next session clears bus_err; unknown CMD 0x7F completes without access
    clear_logs();
    aux_active = 1'b1;
    repeat (2) @(negedge clk);
    check("err_cleared", 32'(bus_err), 32'd0);
    send_byte(8'h7F);
    wait_cmpl("bad_cmpl");
    repeat (5) @(negedge clk);
    check("bad_cmpl_hold", 32'(aux_complete), 32'd1);
    check("bad_no_strb", 32'(we_cyc_q.size() + re_cyc_q.size()), 32'd0);
    check("bad_no_rd", 32'(rd_q.size()), 32'd0);
    end_session();
    check("bad_cmpl_off", 32'(aux_complete), 32'd0);

    // Abort after the 2nd data byte of a 4-byte WRITE
    clear_logs();
    aux_active = 1'b1;
    send_byte(8'h01);
    send_byte(8'h40);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (4) @(negedge clk);
    aux_active = 1'b0;
    repeat (6) @(negedge clk);
    check("abt_we_cnt", 32'(we_cyc_q.size()), 32'd2);
    check("abt_a1", 32'(we_addr_q[1]), 32'h41);
    check("abt_d1", 32'(we_data_q[1]), 32'h22);
    check("abt_no_cmpl", 32'(cmpl_seen), 32'd0);
    check("abt_ready", 32'(aux_data_out_ready), 32'd0);

    // Reset asserted mid-burst clears outputs immediately
    clear_logs();
    aux_data_in_ready = 1'b0;
    aux_active = 1'b1;
    send_byte(8'h02);
    send_byte(8'h80);
    send_byte(8'h08);
    repeat (4) @(negedge clk);
    check("mid_rbuf", 32'(aux_data_in), 32'hDA);
    check("mid_addr", 32'(bus_addr), 32'h80);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_outs", 32'({aux_complete, aux_data_out_ready, aux_data_in_valid, bus_we, bus_re,
                               bus_err, bus_addr, bus_wdata, aux_data_in}), 32'd0);
    aux_active = 1'b0;
    aux_data_in_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    check("no_collide", 32'(collide), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
